// File: rtl/greenhouse_zone_ctrl.sv
// greenhouse_zone_ctrl
//
// Multi-zone greenhouse climate controller. Every zone takes one temperature
// sample on the shared `sample` strobe. It compares the sample against its own
// setpoint using a hysteresis deadband, then drives independent heat and cool
// outputs. A minimum dwell time separates successive actuator changes in a
// zone. Each zone also raises an alarm when its temperature leaves a wider
// band around the setpoint. All zones update in parallel on the same edge.
//
// Parameters:
//   ZONES      - number of independent zones (>= 1)
//   TW         - temperature / setpoint width, unsigned
//   HYST       - half-width of the hysteresis deadband, in temperature LSBs
//   MIN_DWELL  - minimum clock cycles between state transitions of a zone (>= 1)
//   ALARM_BAND - deviation from setpoint that raises the alarm, in LSBs
//
// Ports:
//   clk             in  1         system clock, rising edge
//   rst             in  1         asynchronous active-high reset
//   sample          in  1         new temperature set valid this cycle
//   greenhouse_temp in  ZONES*TW  packed temperatures, zone i at [i*TW +: TW]
//   setpoint        in  ZONES*TW  packed setpoints, same packing
//   enable          in  ZONES     per-zone run enable
//   heat            out ZONES     heater drive, registered
//   cool            out ZONES     cooler drive, registered
//   alarm           out ZONES     out-of-band alarm, registered

module greenhouse_zone_ctrl #(
  parameter int ZONES      = 4,
  parameter int TW         = 8,
  parameter int HYST       = 2,
  parameter int MIN_DWELL  = 16,
  parameter int ALARM_BAND = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample,
  input  logic [ZONES*TW-1:0] greenhouse_temp,
  input  logic [ZONES*TW-1:0] setpoint,
  input  logic [ZONES-1:0]    enable,
  output logic [ZONES-1:0]    heat,
  output logic [ZONES-1:0]    cool,
  output logic [ZONES-1:0]    alarm
);

  localparam int TX = TW + 1;
  localparam int DW = $clog2(MIN_DWELL + 1);

  localparam logic [TW:0]   HYST_X     = TX'(HYST);
  localparam logic [TW:0]   BAND_X     = TX'(ALARM_BAND);
  localparam logic [TW:0]   MAX_X      = {1'b0, {TW{1'b1}}};
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  // The encoding places HEAT on bit 0 and COOL on bit 1. The heat and cool
  // outputs then come straight from the state flops. Both bits can never be
  // set at the same time.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } state_t;

  // Computes a - b one bit wider than the operands. The result clamps at 0,
  // so a setpoint close to 0 cannot wrap around to a large threshold.
  function automatic logic [TW-1:0] sat_sub(input logic [TW-1:0] a,
                                            input logic [TW:0]   b);
    logic [TW:0] ax;
    ax = {1'b0, a};
    if (ax < b) begin
      return '0;
    end
    return TW'(ax - b);
  endfunction

  // Computes a + b one bit wider than the operands. The result clamps at the
  // largest representable temperature, so a setpoint near the top of the
  // range cannot wrap around to a small threshold.
  function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] a,
                                            input logic [TW:0]   b);
    logic [TW:0] sum;
    sum = {1'b0, a} + b;
    if (sum > MAX_X) begin
      return '1;
    end
    return TW'(sum);
  endfunction

  for (genvar z = 0; z < ZONES; z++) begin : g_zone

    logic [TW-1:0] t;
    logic [TW-1:0] sp;
    logic [TW-1:0] lo;
    logic [TW-1:0] hi;
    logic [TW-1:0] alo;
    logic [TW-1:0] ahi;
    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic          alarm_q;
    logic          alarm_d;
    logic          ready;

    assign t   = greenhouse_temp[z*TW +: TW];
    assign sp  = setpoint[z*TW +: TW];
    assign lo  = sat_sub(sp, HYST_X);
    assign hi  = sat_add(sp, HYST_X);
    assign alo = sat_sub(sp, BAND_X);
    assign ahi = sat_add(sp, BAND_X);

    // A transition loads the dwell counter with MIN_DWELL. The counter then
    // counts down one step per edge. The edge that takes the counter from 1
    // to 0 is the MIN_DWELL-th edge after the transition, so the zone may
    // already move again on that edge. Zones that are idle or re-enabled hold
    // the counter at 0 and can always move.
    assign ready = (dwell_q <= DWELL_ONE);

    // Next-state logic for this zone. A disabled zone is forced to IDLE with
    // its dwell and alarm cleared, and this takes priority over any sample.
    // When enabled, the alarm is re-evaluated on every sample whatever the
    // dwell state. The heat/cool FSM moves only when the dwell has elapsed.
    // HEAT and COOL can only return to IDLE, so a reversal always waits out
    // a full dwell in IDLE.
    always_comb begin
      state_d = state_q;
      dwell_d = (dwell_q != '0) ? (dwell_q - DWELL_ONE) : '0;
      alarm_d = alarm_q;

      if (!enable[z]) begin
        state_d = IDLE;
        dwell_d = '0;
        alarm_d = 1'b0;
      end else if (sample) begin
        alarm_d = (t < alo) || (t > ahi);
        if (ready) begin
          case (state_q)
            IDLE: begin
              if (t < lo) begin
                state_d = HEAT;
              end else if (t > hi) begin
                state_d = COOL;
              end
            end
            HEAT: begin
              if (t >= sp) begin
                state_d = IDLE;
              end
            end
            COOL: begin
              if (t <= sp) begin
                state_d = IDLE;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
          if (state_d != state_q) begin
            dwell_d = DWELL_LOAD;
          end
        end
      end
    end

    // State, dwell and alarm registers. Reset clears them at once, so an
    // actuator that is running drops out without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        dwell_q <= '0;
        alarm_q <= 1'b0;
      end else begin
        state_q <= state_d;
        dwell_q <= dwell_d;
        alarm_q <= alarm_d;
      end
    end

    assign heat[z]  = state_q[0];
    assign cool[z]  = state_q[1];
    assign alarm[z] = alarm_q;

  end : g_zone

endmodule

// File: tb/tb_greenhouse_zone_ctrl.sv
// tb_greenhouse_zone_ctrl
//
// Self-checking bench for greenhouse_zone_ctrl with two zones and a dwell of
// 4 cycles. A table of single-cycle vectors lists the inputs and the outputs
// expected after the edge. Each applied vector pushes its expectation onto a
// scoreboard queue. The expectation is popped and compared once the edge has
// passed. Hand-written sequences cover the asynchronous reset.

module tb_greenhouse_zone_ctrl;

  localparam int ZONES      = 2;
  localparam int TW         = 8;
  localparam int HYST       = 2;
  localparam int MIN_DWELL  = 4;
  localparam int ALARM_BAND = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                sample;
  logic [ZONES*TW-1:0] greenhouse_temp;
  logic [ZONES*TW-1:0] setpoint;
  logic [ZONES-1:0]    enable;
  logic [ZONES-1:0]    heat;
  logic [ZONES-1:0]    cool;
  logic [ZONES-1:0]    alarm;

  typedef struct {
    logic       smp;
    logic [1:0] en;
    logic [7:0] t0;
    logic [7:0] sp0;
    logic [7:0] t1;
    logic [7:0] sp1;
    logic [1:0] h;
    logic [1:0] c;
    logic [1:0] a;
  } vec_t;

  typedef struct {
    int         id;
    logic [1:0] h;
    logic [1:0] c;
    logic [1:0] a;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  greenhouse_zone_ctrl #(
    .ZONES     (ZONES),
    .TW        (TW),
    .HYST      (HYST),
    .MIN_DWELL (MIN_DWELL),
    .ALARM_BAND(ALARM_BAND)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample         (sample),
    .greenhouse_temp(greenhouse_temp),
    .setpoint       (setpoint),
    .enable         (enable),
    .heat           (heat),
    .cool           (cool),
    .alarm          (alarm)
  );

  always #5 clk = ~clk;

  // Watchdog so that a stuck run still terminates with a visible failure.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void add_full(input logic smp, input logic [1:0] en,
                                   input logic [7:0] t0, input logic [7:0] sp0,
                                   input logic [7:0] t1, input logic [7:0] sp1,
                                   input logic [1:0] h, input logic [1:0] c,
                                   input logic [1:0] a);
    vec_t v;
    v.smp = smp; v.en = en;
    v.t0 = t0; v.sp0 = sp0; v.t1 = t1; v.sp1 = sp1;
    v.h = h; v.c = c; v.a = a;
    vecs.push_back(v);
  endfunction

  // Vector for zone 0 only. Zone 1 is held enabled and sits exactly on its
  // setpoint, so it is expected to stay IDLE with no alarm.
  function automatic void add0(input logic smp, input logic [7:0] t0,
                               input logic [7:0] sp0, input logic h0,
                               input logic c0, input logic a0);
    add_full(smp, 2'b11, t0, sp0, 8'd100, 8'd100,
             {1'b0, h0}, {1'b0, c0}, {1'b0, a0});
  endfunction

  function automatic void add0_rep(input int n, input logic smp,
                                   input logic [7:0] t0, input logic [7:0] sp0,
                                   input logic h0, input logic c0,
                                   input logic a0);
    for (int i = 0; i < n; i++) begin
      add0(smp, t0, sp0, h0, c0, a0);
    end
  endfunction

  task automatic compare(input string name, input logic [1:0] act,
                         input logic [1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      compare($sformatf("v%0d heat", e.id), heat, e.h);
      compare($sformatf("v%0d cool", e.id), cool, e.c);
      compare($sformatf("v%0d alarm", e.id), alarm, e.a);
      compare($sformatf("v%0d exclusive", e.id), heat & cool, 2'b00);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    sample          = v.smp;
    enable          = v.en;
    greenhouse_temp = {v.t1, v.t0};
    setpoint        = {v.sp1, v.sp0};
    e.id = id; e.h = v.h; e.c = v.c; e.a = v.a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    vec_t hv;

    // Vector table. Each entry is one cycle, and its expected outputs are
    // the values seen just after that cycle's edge.
    add0(1, 100, 100, 0, 0, 0);            // after reset: all quiet
    // heat cycle
    add0(1, 97, 100, 1, 0, 0);             // 97 < lo=98 -> HEAT
    add0_rep(3, 0, 97, 100, 1, 0, 0);
    add0(1, 99, 100, 1, 0, 0);             // dwell over, 99 < sp -> stay
    add0(1, 100, 100, 0, 0, 0);            // t >= sp -> IDLE
    // deadband
    add0_rep(3, 0, 100, 100, 0, 0, 0);
    add0(1, 98, 100, 0, 0, 0);             // t == lo is inside the deadband
    add0(1, 102, 100, 0, 0, 0);            // t == hi is inside the deadband
    add0(1, 103, 100, 0, 1, 0);            // t > hi -> COOL
    add0_rep(3, 0, 103, 100, 0, 1, 0);
    add0(1, 100, 100, 0, 0, 0);            // t <= sp -> IDLE
    // dwell and no direct reversal
    add0_rep(3, 0, 100, 100, 0, 0, 0);
    add0(1, 97, 100, 1, 0, 0);
    add0_rep(3, 1, 120, 100, 1, 0, 1);     // blocked by dwell, alarm live
    add0(1, 120, 100, 0, 0, 1);            // 4th edge: HEAT -> IDLE
    add0_rep(3, 1, 120, 100, 0, 0, 1);     // IDLE dwell blocks COOL
    add0(1, 120, 100, 0, 1, 1);            // 4 cycles later: COOL
    add0_rep(3, 0, 120, 100, 0, 1, 1);     // alarm holds between samples
    add0(1, 100, 100, 0, 0, 0);
    // saturation
    add0_rep(3, 0, 100, 100, 0, 0, 0);
    add0(1, 0, 1, 0, 0, 0);                // lo clamps to 0
    add0(1, 255, 254, 0, 0, 0);            // hi clamps to 255
    // alarm band edges
    add0(1, 89, 100, 1, 0, 1);             // 89 < alo=90
    add0(1, 90, 100, 1, 0, 0);             // t == alo is in band
    add0_rep(2, 1, 111, 100, 1, 0, 1);     // 111 > ahi=110
    add0(1, 100, 100, 0, 0, 0);
    // enable handling
    add0_rep(3, 0, 100, 100, 0, 0, 0);
    add_full(1, 2'b11, 97, 100, 85, 100, 2'b11, 2'b00, 2'b10);
    add_full(1, 2'b01, 97, 100, 85, 100, 2'b01, 2'b00, 2'b00);
    add_full(1, 2'b11, 97, 100, 97, 100, 2'b11, 2'b00, 2'b00);

    // Reset state, checked between edges while reset is held.
    rst             = 1'b1;
    sample          = 1'b0;
    enable          = 2'b11;
    greenhouse_temp = {8'd100, 8'd100};
    setpoint        = {8'd100, 8'd100};
    #2;
    compare("reset heat", heat, 2'b00);
    compare("reset cool", cool, 2'b00);
    compare("reset alarm", alarm, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Enter HEAT on zone 0, then assert reset between edges.
    hv.smp = 1'b1; hv.en = 2'b11;
    hv.t0 = 8'd97; hv.sp0 = 8'd100; hv.t1 = 8'd100; hv.sp1 = 8'd100;
    hv.h = 2'b01; hv.c = 2'b00; hv.a = 2'b00;
    apply_stimulus(hv, 0);
    @(negedge clk);
    sample = 1'b0;
    #2;
    compare("pre-reset heat", heat, 2'b01);
    rst = 1'b1;
    #1;
    compare("async reset heat", heat, 2'b00);
    compare("async reset cool", cool, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], i + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
